// File: rtl/dmem_lsu.sv
// Load/store unit bridging the core data port to a word-wide synchronous RAM.
// Sub-word stores are done as read-modify-write because the RAM has no byte enables.
module dmem_lsu #(
    parameter  int unsigned DATA_SIZE = 1024,
    localparam int unsigned ADDR_W    = $clog2(DATA_SIZE)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [31:0]       ram_q
);

    localparam int unsigned LAT_AW = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [LAT_AW-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [31:0]         r_resp_rdata;
    logic                r_resp_err;
    logic [31:0]         r_ram_data;

    logic                w_accept;
    logic                w_dec_err;
    logic                w_dec_sw;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merge;
    logic                w_unused_addr;

    // Address bits above the RAM range alias and are deliberately dropped.
    assign w_unused_addr = ^req_addr[31:LAT_AW];

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_dec_sw = req_we && (req_funct3 == 3'b010);

    // Illegal funct3 or misaligned access, decided from the live request.
    always_comb begin
        w_dec_err = 1'b0;
        case (req_funct3)
            3'b000:         w_dec_err = 1'b0;
            3'b001:         w_dec_err = req_addr[0];
            3'b010:         w_dec_err = |req_addr[1:0];
            3'b100, 3'b101: w_dec_err = req_we || (req_funct3[0] && req_addr[0]);
            default:        w_dec_err = 1'b1;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_dec_err)     w_next_state = S_DONE;
                    else if (w_dec_sw) w_next_state = S_WR;
                    else               w_next_state = S_RD;
                end
            end
            S_RD:    w_next_state = S_CAP;
            S_CAP:   w_next_state = r_we ? S_WR : S_DONE;
            S_WR:    w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Little-endian lane selection and extension / merge of the RAM word.
    always_comb begin
        w_byte = ram_q[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = ram_q[7:0];
            2'd1: w_byte = ram_q[15:8];
            2'd2: w_byte = ram_q[23:16];
            2'd3: w_byte = ram_q[31:24];
            default: w_byte = ram_q[7:0];
        endcase
        w_half = r_addr[1] ? ram_q[31:16] : ram_q[15:0];

        w_load_data = ram_q;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = ram_q;
        endcase

        w_merge = ram_q;
        if (r_funct3[0]) begin
            if (r_addr[1]) w_merge[31:16] = r_wdata;
            else           w_merge[15:0]  = r_wdata;
        end else begin
            case (r_addr[1:0])
                2'd0: w_merge[7:0]   = r_wdata[7:0];
                2'd1: w_merge[15:8]  = r_wdata[7:0];
                2'd2: w_merge[23:16] = r_wdata[7:0];
                2'd3: w_merge[31:24] = r_wdata[7:0];
                default: w_merge = ram_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= 16'd0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_ram_data   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we         <= req_we;
                r_funct3     <= req_funct3;
                r_addr       <= req_addr[LAT_AW-1:0];
                r_wdata      <= req_wdata[15:0];
                r_resp_rdata <= 32'd0;
                r_resp_err   <= w_dec_err;
                if (w_dec_sw && !w_dec_err) r_ram_data <= req_wdata;
            end
            if (r_state == S_CAP) begin
                if (r_we) r_ram_data   <= w_merge;
                else      r_resp_rdata <= w_load_data;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_DONE);
    assign ram_rden    = (r_state == S_RD);
    assign ram_wren    = (r_state == S_WR);
    assign resp_rdata  = r_resp_rdata;
    assign resp_err    = r_resp_err;
    assign ram_address = r_addr[LAT_AW-1:2];
    assign ram_data    = r_ram_data;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural model of the memory and access rules,
// with a single per-cycle compare process against the DUT.
module tb_dmem_lsu;

    localparam int unsigned DATA_SIZE = 1024;
    localparam int unsigned ADDR_W    = 10;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic              ram_rden;
    logic [31:0]       ram_q = 32'd0;

    dmem_lsu #(.DATA_SIZE(DATA_SIZE)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_rden(ram_rden), .ram_q(ram_q)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Environment RAM (synchronous read) with a preload port.
    logic [31:0]       env_mem [DATA_SIZE];
    logic              pl_we = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [31:0]       pl_data = 32'd0;
    int                wren_cnt = 0;
    always @(posedge CLK) begin
        if (pl_we) env_mem[pl_addr] <= pl_data;
        if (ram_wren) begin
            env_mem[ram_address] <= ram_data;
            wren_cnt <= wren_cnt + 1;
        end
        if (ram_rden) ram_q <= env_mem[ram_address];
    end

    // Reference model state, written only by the stimulus process.
    logic [31:0] ref_mem [16];
    logic        pending = 1'b0;
    int          p_start = 0;
    int          p_kind = 0;     // 0 err, 1 SW, 2 load, 3 sub-word store
    int          p_lat = 1;
    logic [31:0] p_word = 32'd0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_wdata = 32'd0;
    logic        have_exp = 1'b0;
    int          exp_wren = 0;
    logic        chk_en = 1'b0;
    logic        lit_rd_en = 1'b0;
    logic [31:0] lit_rd = 32'd0;
    logic        lit_err = 1'b0;
    logic        lit_wd_en = 1'b0;
    logic [31:0] lit_wd = 32'd0;
    logic        zero_probe = 1'b0;
    logic        mem_probe_en = 1'b0;
    int          mem_probe_idx = 0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, expv, cyc);
        end
    endtask

    // Single compare process, sampled on the falling edge.
    always @(negedge CLK) begin
        int   rel;
        logic busy, e_rden, e_wren, e_rv;
        rel    = cyc - p_start;
        busy   = pending && rel >= 1 && rel <= p_lat;
        e_rden = busy && rel == 1 && (p_kind == 2 || p_kind == 3);
        e_wren = busy && ((p_kind == 1 && rel == 1) || (p_kind == 3 && rel == 3));
        e_rv   = busy && rel == p_lat;
        if (zero_probe) begin
            chk("reset req_ready", 32'(req_ready), 32'd1);
            chk("reset resp_valid", 32'(resp_valid), 32'd0);
            chk("reset resp_rdata", resp_rdata, 32'd0);
            chk("reset resp_err", 32'(resp_err), 32'd0);
            chk("reset ram_wren", 32'(ram_wren), 32'd0);
            chk("reset ram_rden", 32'(ram_rden), 32'd0);
            chk("reset ram_address", 32'(ram_address), 32'd0);
            chk("reset ram_data", ram_data, 32'd0);
        end else if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(!busy));
            chk("ram_rden", 32'(ram_rden), 32'(e_rden));
            chk("ram_wren", 32'(ram_wren), 32'(e_wren));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            if (e_rden || e_wren) chk("ram_address", 32'(ram_address), p_word);
            if (e_wren) chk("ram_data", ram_data, exp_wdata);
            if (e_wren && lit_wd_en) chk("ram_data literal", ram_data, lit_wd);
            if (e_rv || (!busy && have_exp)) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
            end
            if (e_rv && lit_rd_en) begin
                chk("resp_rdata literal", resp_rdata, lit_rd);
                chk("resp_err literal", 32'(resp_err), 32'(lit_err));
            end
        end
        if (mem_probe_en) begin
            chk("ram contents", env_mem[mem_probe_idx], ref_mem[mem_probe_idx]);
            chk("write count", 32'(wren_cnt), 32'(exp_wren));
        end
    end

    // Issue one request; the model computes outcome and timing from the access rules.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int gap);
        int          widx, sh, hs, lat;
        logic [31:0] word, b, h, nw, rd;
        logic        legal, mis, err;
        repeat (gap) @(negedge CLK);
        @(negedge CLK); #1;
        widx  = int'((a >> 2) & 32'(DATA_SIZE - 1));
        word  = ref_mem[widx];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
        err   = !legal || mis;
        sh    = 8 * int'(a % 4);
        hs    = 16 * int'((a / 2) % 2);
        rd    = 32'd0;
        nw    = word;
        if (err) begin
            p_kind = 0; lat = 1;
        end else if (we) begin
            if (f3 == 3'd2) begin
                p_kind = 1; lat = 2; nw = wd;
            end else if (f3 == 3'd0) begin
                p_kind = 3; lat = 4;
                nw = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end else begin
                p_kind = 3; lat = 4;
                nw = (word & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
            end
            ref_mem[widx] = nw;
            exp_wren++;
        end else begin
            p_kind = 2; lat = 3;
            b = (word >> sh) & 32'hFF;
            h = (word >> hs) & 32'hFFFF;
            case (f3)
                3'd0:    rd = b[7]  ? (b | 32'hFFFF_FF00) : b;
                3'd1:    rd = h[15] ? (h | 32'hFFFF_0000) : h;
                3'd4:    rd = b;
                3'd5:    rd = h;
                default: rd = word;
            endcase
        end
        p_lat = lat; p_word = 32'(widx); exp_rdata = rd; exp_err = err;
        exp_wdata = nw; have_exp = 1'b1;
        p_start = cyc; pending = 1'b1;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int r = 1; r <= lat; r++) begin
            @(negedge CLK); #1;
            if (r < lat && $urandom_range(0, 1) == 1) begin
                req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
        end
        lit_rd_en = 1'b0;
        lit_wd_en = 1'b0;
    endtask

    task automatic expect_lit(input logic [31:0] v, input logic e);
        lit_rd_en = 1'b1; lit_rd = v; lit_err = e;
    endtask

    initial begin
        logic [31:0] v;
        logic [2:0]  f3;
        logic        we;
        // Reset and preload words 0..15 (word 2 fixed for directed cases).
        for (int i = 0; i < 16; i++) begin
            v = (i == 2) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = v;
            @(negedge CLK); #1;
            pl_we = 1'b1; pl_addr = ADDR_W'(i); pl_data = v;
        end
        @(negedge CLK); #1;
        pl_we = 1'b0;
        zero_probe = 1'b1;
        @(negedge CLK); #1;
        zero_probe = 1'b0;
        RESET_N = 1'b1; have_exp = 1'b1; chk_en = 1'b1;

        // Directed loads of word 2.
        expect_lit(32'hDEAD_BEEF, 1'b0); issue(1'b0, 3'd2, 32'h8, 32'd0, 0);
        expect_lit(32'hFFFF_FFBE, 1'b0); issue(1'b0, 3'd0, 32'h9, 32'd0, 0);
        expect_lit(32'h0000_00BE, 1'b0); issue(1'b0, 3'd4, 32'h9, 32'd0, 0);
        expect_lit(32'hFFFF_DEAD, 1'b0); issue(1'b0, 3'd1, 32'hA, 32'd0, 0);
        expect_lit(32'h0000_DEAD, 1'b0); issue(1'b0, 3'd5, 32'hA, 32'd0, 0);
        // Sub-word store, word store, readbacks.
        lit_wd_en = 1'b1; lit_wd = 32'hDE55_BEEF;
        expect_lit(32'd0, 1'b0);         issue(1'b1, 3'd0, 32'hA, 32'h1234_5655, 0);
        expect_lit(32'hDE55_BEEF, 1'b0); issue(1'b0, 3'd2, 32'h8, 32'd0, 0);
        lit_wd_en = 1'b1; lit_wd = 32'hCAFE_F00D;
        issue(1'b1, 3'd2, 32'hC, 32'hCAFE_F00D, 1);
        expect_lit(32'hCAFE_F00D, 1'b0); issue(1'b0, 3'd2, 32'hC, 32'd0, 0);
        // Error cases.
        expect_lit(32'd0, 1'b1); issue(1'b1, 3'd1, 32'h3, 32'hFFFF_FFFF, 0);
        expect_lit(32'd0, 1'b1); issue(1'b0, 3'd2, 32'h6, 32'd0, 0);
        expect_lit(32'd0, 1'b1); issue(1'b0, 3'd3, 32'h8, 32'd0, 0);

        // Reset landing in CAP of an SB must abandon the write.
        @(negedge CLK); #1;
        p_kind = 3; p_lat = 4; p_word = 32'd2; exp_wdata = 32'd0;
        p_start = cyc; pending = 1'b1;
        req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h9; req_wdata = 32'h0000_0077;
        req_valid = 1'b1;
        @(negedge CLK); #1;
        req_valid = 1'b0;
        @(negedge CLK); #1;
        RESET_N = 1'b0; chk_en = 1'b0; zero_probe = 1'b1;
        @(negedge CLK); #1;
        zero_probe = 1'b0; RESET_N = 1'b1; pending = 1'b0;
        exp_rdata = 32'd0; exp_err = 1'b0; have_exp = 1'b1; chk_en = 1'b1;
        mem_probe_idx = 2; mem_probe_en = 1'b1;
        @(negedge CLK); #1;
        mem_probe_en = 1'b0;

        // Randomized traffic over words 0..15 with aliased upper address bits.
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            issue(we, f3, $urandom & 32'hFFFF_F03F, $urandom, $urandom_range(0, 2));
        end

        for (int i = 0; i < 16; i++) begin
            @(negedge CLK); #1;
            mem_probe_idx = i; mem_probe_en = 1'b1;
        end
        @(negedge CLK); #1;
        mem_probe_en = 1'b0;
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
